// File: rtl/camerica_pkg.sv
// Shared types and constants for the camera-bus transmitter.
package camerica_pkg;

    localparam int PIXEL_W = 12;
    localparam logic [PIXEL_W-1:0] PAT_CONST_VALUE = 12'hA5A;

    typedef enum logic [1:0] {
        PAT_RAMP    = 2'd0,
        PAT_CHECKER = 2'd1,
        PAT_EXT     = 2'd2,
        PAT_CONST   = 2'd3
    } pattern_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/cam_tx_clkgen.sv
// Divides clk into cam_clk; update_o marks the clk cycle in which cam_clk falls.
module cam_tx_clkgen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    output logic cam_clk_o,
    output logic update_o
);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic             cam_clk_q, cam_clk_d;
    logic             wrap;

    always_comb begin
        wrap      = (div_cnt_q == DIV_W'(CLK_DIV - 1));
        div_cnt_d = wrap ? '0 : div_cnt_q + 1'b1;
        cam_clk_d = wrap ? ~cam_clk_q : cam_clk_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_cnt_q <= '0;
            cam_clk_q <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            cam_clk_q <= cam_clk_d;
        end
    end

    assign cam_clk_o = cam_clk_q;
    assign update_o  = wrap & cam_clk_q;

endmodule

// File: rtl/cam_tx.sv
// Camera-bus transmitter: raster timing, test patterns or external stream,
// with outputs launched on falling cam_clk so the receiver samples them on rising.
module cam_tx
    import camerica_pkg::*;
#(
    parameter int H_ACTIVE = 320,
    parameter int H_BLANK  = 32,
    parameter int V_ACTIVE = 256,
    parameter int V_BLANK  = 8,
    parameter int CLK_DIV  = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic [1:0]         pattern,
    input  logic [PIXEL_W-1:0] src_pixel,
    input  logic               src_valid,
    output logic               src_ready,
    output logic               cam_clk,
    output logic [PIXEL_W-1:0] cam_pixel,
    output logic               cam_hsync,
    output logic               cam_vsync,
    output logic               busy,
    output logic               frame_done,
    output logic               underflow,
    output logic [15:0]        frame_count
);
    localparam int H_TOT = H_ACTIVE + H_BLANK;
    localparam int V_TOT = V_ACTIVE + V_BLANK;
    localparam int H_W   = (H_TOT > 1) ? $clog2(H_TOT) : 1;
    localparam int V_W   = (V_TOT > 1) ? $clog2(V_TOT) : 1;

    logic update;

    cam_tx_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
        .clk_i    (clk),
        .rst_ni   (rst),
        .cam_clk_o(cam_clk),
        .update_o (update)
    );

    state_t             state_q, state_d;
    pattern_t           pat_q, pat_d;
    logic [H_W-1:0]     h_cnt_q, h_cnt_d;
    logic [V_W-1:0]     v_cnt_q, v_cnt_d;
    logic               pend_q, pend_d;
    logic [PIXEL_W-1:0] pix_q, pix_d;
    logic               hs_q, hs_d;
    logic               vs_q, vs_d;
    logic               fd_q, fd_d;
    logic               uf_q, uf_d;
    logic [15:0]        frame_count_q, frame_count_d;

    logic               start, emit, vis, vact, rdy;
    logic [H_W-1:0]     eh;
    logic [V_W-1:0]     ev;
    pattern_t           epat;
    logic [PIXEL_W-1:0] pat_pix;

    always_comb begin
        state_d       = state_q;
        pat_d         = pat_q;
        h_cnt_d       = h_cnt_q;
        v_cnt_d       = v_cnt_q;
        pend_d        = pend_q;
        pix_d         = pix_q;
        hs_d          = hs_q;
        vs_d          = vs_q;
        fd_d          = 1'b0;
        uf_d          = uf_q;
        frame_count_d = frame_count_q;
        start         = 1'b0;
        emit          = 1'b0;
        rdy           = 1'b0;
        eh            = h_cnt_q;
        ev            = v_cnt_q;
        epat          = pat_q;

        // pend_q: the last slot of the frame is on the bus; the frame closes at the next update
        if (update) begin
            case (state_q)
                ST_IDLE: start = enable;
                ST_RUN: begin
                    if (pend_q) begin
                        fd_d          = 1'b1;
                        frame_count_d = frame_count_q + 16'd1;
                        start         = enable;
                        if (!enable) begin
                            state_d = ST_IDLE;
                            pend_d  = 1'b0;
                            pix_d   = '0;
                            hs_d    = 1'b0;
                            vs_d    = 1'b0;
                        end
                    end else begin
                        emit = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
            if (start) begin
                state_d = ST_RUN;
                pend_d  = 1'b0;
                pat_d   = pattern_t'(pattern);
                epat    = pattern_t'(pattern);
                eh      = '0;
                ev      = '0;
                emit    = 1'b1;
            end
        end

        vact = (int'(ev) < V_ACTIVE);
        vis  = vact && (int'(eh) < H_ACTIVE);

        case (epat)
            PAT_RAMP:    pat_pix = PIXEL_W'((int'(eh) + 4 * int'(ev)) % 4096);
            PAT_CHECKER: pat_pix = (((int'(eh) / 8) % 2) != ((int'(ev) / 8) % 2)) ? 12'hFFF : 12'h000;
            PAT_EXT:     pat_pix = src_valid ? src_pixel : '0;
            default:     pat_pix = PAT_CONST_VALUE;
        endcase

        if (emit) begin
            rdy  = vis && (epat == PAT_EXT);
            hs_d = vis;
            vs_d = vact;
            pix_d = vis ? pat_pix : '0;
            if (rdy && !src_valid) uf_d = 1'b1;
            if (int'(eh) == H_TOT - 1) begin
                h_cnt_d = '0;
                if (int'(ev) == V_TOT - 1) begin
                    v_cnt_d = '0;
                    pend_d  = 1'b1;
                end else begin
                    v_cnt_d = ev + 1'b1;
                end
            end else begin
                h_cnt_d = eh + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            pat_q         <= PAT_RAMP;
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            pend_q        <= 1'b0;
            pix_q         <= '0;
            hs_q          <= 1'b0;
            vs_q          <= 1'b0;
            fd_q          <= 1'b0;
            uf_q          <= 1'b0;
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            pat_q         <= pat_d;
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            pend_q        <= pend_d;
            pix_q         <= pix_d;
            hs_q          <= hs_d;
            vs_q          <= vs_d;
            fd_q          <= fd_d;
            uf_q          <= uf_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign src_ready   = rdy;
    assign cam_pixel   = pix_q;
    assign cam_hsync   = hs_q;
    assign cam_vsync   = vs_q;
    assign busy        = (state_q == ST_RUN);
    assign frame_done  = fd_q;
    assign underflow   = uf_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_cam_tx.sv
// Scoreboard bench: a raster model queues every receiver sample; a monitor
// compares what the DUT shows at each rising cam_clk.
module tb_cam_tx;
    localparam int HA = 20, HB = 4, VA = 12, VB = 3;
    localparam int HT = HA + HB, VT = VA + VB;
    localparam int NF = 6;
    localparam int DROP_IDX = 7;

    typedef struct packed {
        logic        ext;
        logic        hs;
        logic        vs;
        logic [11:0] pix;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b0;
    logic [1:0]  pattern = 2'd0;
    logic [11:0] src_pixel;
    logic        src_valid;

    logic        src_ready, cam_clk, cam_hsync, cam_vsync, busy, frame_done, underflow;
    logic [11:0] cam_pixel;
    logic [15:0] frame_count;

    logic [1:0]  x_ready, x_clk, x_hs, x_vs, x_busy, x_fd, x_uf;
    logic [11:0] x_pix[2];
    logic [15:0] x_fc[2];

    int checks = 0;
    int errors = 0;
    exp_t exp_q[$];
    logic [11:0] ext_q[$];
    int  plist[NF];
    bit  uf_model = 1'b0;
    int  rdy_total = 0;
    int  fd_cnt = 0;

    always #5 clk = ~clk;

    cam_tx #(.H_ACTIVE(HA), .H_BLANK(HB), .V_ACTIVE(VA), .V_BLANK(VB), .CLK_DIV(2)) dut (
        .clk(clk), .rst(rst), .enable(enable), .pattern(pattern),
        .src_pixel(src_pixel), .src_valid(src_valid), .src_ready(src_ready),
        .cam_clk(cam_clk), .cam_pixel(cam_pixel), .cam_hsync(cam_hsync), .cam_vsync(cam_vsync),
        .busy(busy), .frame_done(frame_done), .underflow(underflow), .frame_count(frame_count)
    );

    cam_tx #(.H_ACTIVE(HA), .H_BLANK(HB), .V_ACTIVE(VA), .V_BLANK(VB), .CLK_DIV(1)) dut_d1 (
        .clk(clk), .rst(rst), .enable(enable), .pattern(pattern),
        .src_pixel(src_pixel), .src_valid(src_valid), .src_ready(x_ready[0]),
        .cam_clk(x_clk[0]), .cam_pixel(x_pix[0]), .cam_hsync(x_hs[0]), .cam_vsync(x_vs[0]),
        .busy(x_busy[0]), .frame_done(x_fd[0]), .underflow(x_uf[0]), .frame_count(x_fc[0])
    );

    cam_tx #(.H_ACTIVE(HA), .H_BLANK(HB), .V_ACTIVE(VA), .V_BLANK(VB), .CLK_DIV(3)) dut_d3 (
        .clk(clk), .rst(rst), .enable(enable), .pattern(pattern),
        .src_pixel(src_pixel), .src_valid(src_valid), .src_ready(x_ready[1]),
        .cam_clk(x_clk[1]), .cam_pixel(x_pix[1]), .cam_hsync(x_hs[1]), .cam_vsync(x_vs[1]),
        .busy(x_busy[1]), .frame_done(x_fd[1]), .underflow(x_uf[1]), .frame_count(x_fc[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t slot(input int p, input int h, input int v);
        exp_t e;
        e.vs  = (v < VA);
        e.hs  = (h < HA) && (v < VA);
        e.ext = (p == 2);
        case (p)
            0:       e.pix = 12'((h + 4 * v) % 4096);
            1:       e.pix = (((h / 8) % 2) != ((v / 8) % 2)) ? 12'hFFF : 12'h000;
            2:       e.pix = 12'h000;
            default: e.pix = 12'hA5A;
        endcase
        if (!e.hs) e.pix = 12'h000;
        return e;
    endfunction

    task automatic wait_high(input int which, input int limit, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < limit; n++) begin
            @(negedge clk);
            if ((which == 0) ? busy : frame_done) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    // External source: incrementing data, one forced gap plus occasional random gaps
    initial begin
        logic [11:0] nxt;
        int          idx;
        bit          r;
        nxt = 12'($urandom);
        idx = 0;
        src_pixel = nxt;
        src_valid = 1'b1;
        @(posedge rst);
        forever begin
            @(negedge clk);
            r = src_ready;
            if (r) begin
                rdy_total++;
                idx++;
                if (src_valid) begin
                    ext_q.push_back(src_pixel);
                    nxt = nxt + 12'd1;
                end else begin
                    ext_q.push_back(12'h000);
                    uf_model = 1'b1;
                end
                @(posedge clk);
                #1;
                src_pixel = nxt;
                src_valid = (idx != DROP_IDX) && ($urandom_range(0, 19) != 0);
            end
        end
    end

    // Receiver-side monitor for the main DUT
    initial begin
        exp_t        e;
        logic [11:0] ep;
        logic        pcc, pfd;
        pcc = 1'b0;
        pfd = 1'b0;
        @(posedge rst);
        forever begin
            @(negedge clk);
            if (cam_clk && !pcc) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
                ep = e.pix;
                if (e.ext && e.hs) begin
                    chk("ext_available", 32'(ext_q.size() != 0), 32'd1);
                    if (ext_q.size() != 0) ep = ext_q.pop_front();
                end
                chk("slot_hs_vs_pix", {cam_hsync, cam_vsync, cam_pixel}, {e.hs, e.vs, ep});
            end
            if (frame_done) begin
                fd_cnt++;
                chk("frame_done_width", 32'(pfd), 32'd0);
                chk("frame_count", 32'(frame_count), 32'(16'(32'hFFFE + fd_cnt)));
                chk("busy_at_done", 32'(busy), 32'(fd_cnt < NF));
                chk("underflow", 32'(underflow), 32'(uf_model));
            end
            pcc = cam_clk;
            pfd = frame_done;
        end
    end

    // cam_clk period and launch-on-falling-edge checks for all three dividers
    initial begin
        logic        cc[3], pcc[3];
        logic [13:0] d[3], pd[3];
        int          per[3];
        bit          seen[3];
        int          divs[3];
        divs[0] = 2; divs[1] = 1; divs[2] = 3;
        for (int i = 0; i < 3; i++) begin
            pcc[i] = 1'b0; pd[i] = '0; per[i] = 0; seen[i] = 1'b0;
        end
        @(posedge rst);
        forever begin
            @(negedge clk);
            cc[0] = cam_clk;  d[0] = {cam_pixel, cam_hsync, cam_vsync};
            cc[1] = x_clk[0]; d[1] = {x_pix[0], x_hs[0], x_vs[0]};
            cc[2] = x_clk[1]; d[2] = {x_pix[1], x_hs[1], x_vs[1]};
            for (int i = 0; i < 3; i++) begin
                per[i]++;
                if (cc[i] && !pcc[i]) begin
                    if (seen[i]) chk($sformatf("cam_clk_period_%0d", i), per[i], 2 * divs[i]);
                    seen[i] = 1'b1;
                    per[i]  = 0;
                end
                if (d[i] !== pd[i]) chk($sformatf("launch_on_fall_%0d", i), {pcc[i], cc[i]}, 2'b10);
                pcc[i] = cc[i];
                pd[i]  = d[i];
            end
        end
    end

    initial begin
        bit ok;
        int n_ext;
        plist[0] = 0; plist[1] = 2; plist[2] = 1; plist[3] = 3; plist[4] = 2;
        plist[5] = int'($urandom_range(0, 3));
        n_ext = 0;
        exp_q.push_back('0);
        for (int f = 0; f < NF; f++) begin
            if (plist[f] == 2) n_ext++;
            for (int v = 0; v < VT; v++)
                for (int h = 0; h < HT; h++)
                    exp_q.push_back(slot(plist[f], h, v));
        end

        enable  = 1'b1;
        pattern = 2'(plist[0]);
        repeat (6) @(negedge clk);
        chk("rst_main", {src_ready, cam_clk, cam_pixel, cam_hsync, cam_vsync, busy, frame_done, underflow, frame_count}, '0);
        chk("rst_d1", {x_ready[0], x_clk[0], x_pix[0], x_hs[0], x_vs[0], x_busy[0], x_fd[0], x_uf[0], x_fc[0]}, '0);
        chk("rst_d3", {x_ready[1], x_clk[1], x_pix[1], x_hs[1], x_vs[1], x_busy[1], x_fd[1], x_uf[1], x_fc[1]}, '0);
        rst = 1'b1;

        wait_high(0, 20, ok);
        chk("first_frame_start", 32'(ok), 32'd1);
        pattern = 2'(plist[1]);
        repeat (20) @(negedge clk);
        force dut.frame_count_q = 16'hFFFE;
        @(negedge clk);
        release dut.frame_count_q;

        for (int k = 1; k < NF; k++) begin
            wait_high(1, 2 * HT * VT * 4 + 100, ok);
            chk("frame_done_arrives", 32'(ok), 32'd1);
            if (k + 1 < NF) pattern = 2'(plist[k + 1]);
        end
        repeat (5 * HT * 4 + 7) @(negedge clk);
        enable = 1'b0;
        wait_high(1, 2 * HT * VT * 4 + 100, ok);
        chk("last_frame_done_arrives", 32'(ok), 32'd1);
        repeat (300) @(negedge clk);

        chk("frames_total", fd_cnt, NF);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("exp_drained", exp_q.size(), 0);
        chk("ext_drained", ext_q.size(), 0);
        chk("src_ready_total", rdy_total, n_ext * HA * VA);
        chk("underflow_sticky", 32'(underflow), 32'd1);
        chk("frame_count_final", 32'(frame_count), 32'(16'(32'hFFFE + NF)));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cam_tx.md
Name: cam_tx

Overview:
- Camera-bus transmitter/emulator: generates cam_clk, 12-bit pixel, hsync and vsync exactly as the camera drives them into the FPGA's camera-bus receiver.
- Used for loopback self-test of the capture path on the board and as the stimulus source in capture-path benches.
- Pixels come from a built-in test pattern or from an external valid/ready stream.

Parameters:
- H_ACTIVE, 320, visible pixels per line.
- H_BLANK, 32, blank pixel slots per line after the visible pixels.
- V_ACTIVE, 256, visible lines per frame.
- V_BLANK, 8, blank lines per frame after the visible lines.
- CLK_DIV, 2, clk cycles per cam_clk half-period (≥1); one pixel slot = 2*CLK_DIV clk cycles.

Ports:
- clk  in  1  main 50 MHz clock.
- rst  in  1  asynchronous reset, active-low (0 = reset).
- enable  in  1  run request; sampled only at frame boundaries.
- pattern  in  2  0=ramp, 1=checker, 2=external stream, 3=constant 12'hA5A; sampled at frame start.
- src_pixel  in  12  external pixel data.
- src_valid  in  1  external pixel available.
- src_ready  out  1  one-clk pulse: src_pixel consumed this cycle.
- cam_clk  out  1  generated camera pixel clock.
- cam_pixel  out  12  pixel data.
- cam_hsync  out  1  high while the current slot is a visible pixel of a visible line.
- cam_vsync  out  1  high for all slots of visible lines.
- busy  out  1  a frame is in progress.
- frame_done  out  1  one-clk pulse after the last slot of a frame.
- underflow  out  1  sticky: external mode needed a pixel while src_valid was low.
- frame_count  out  16  completed frames, wraps at 16'hFFFF→0.

Behaviour:
- Reset (rst=0, async): all outputs 0; divider, h_cnt, v_cnt, frame_count cleared; state IDLE.
- Divider: div_cnt counts 0..CLK_DIV-1. At wrap, cam_clk toggles. Toggle to 0 is the "update cycle".
- On the update cycle: cam_pixel, cam_hsync and cam_vsync register new values, so they are stable across the following rising cam_clk edge, where the receiver samples.
- State IDLE:
  - cam_clk keeps running; cam_pixel=0, syncs=0, busy=0.
  - On an update cycle with enable=1: latch pattern, h_cnt=v_cnt=0, state RUN, and emit slot (0,0) in the same update cycle.
- State RUN:
  - Each update cycle emits slot (h_cnt, v_cnt), then advances h_cnt.
  - h_cnt wraps at H_ACTIVE+H_BLANK-1 and increments v_cnt.
  - After the last slot (h=H_ACTIVE+H_BLANK-1, v=V_ACTIVE+V_BLANK-1), on the next update cycle:
    - frame_done pulses; frame_count increments.
    - If enable=1: start the next frame back-to-back (pattern re-latched).
    - Else: go to IDLE with outputs zeroed.
- Deasserting enable mid-frame never truncates the frame.
- Slot outputs:
  - vis = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
  - cam_hsync = vis.
  - cam_vsync = (v_cnt < V_ACTIVE).
  - cam_pixel = vis ? pattern value : 0.
- Pattern values, 12-bit truncation:
  - ramp = (h_cnt + v_cnt*4) mod 4096.
  - checker = (h_cnt[3] ^ v_cnt[3]) ? 12'hFFF : 12'h000.
  - constant = 12'hA5A.
- External mode, on vis slots only:
  - src_ready pulses in the update cycle.
  - If src_valid=1: cam_pixel=src_pixel.
  - If src_valid=0: cam_pixel=0 and underflow sets. underflow clears only on reset.
  - src_ready never asserts outside external mode or on blank slots.
- busy = (state==RUN).
- Counter widths: h_cnt ≥ clog2(H_ACTIVE+H_BLANK); v_cnt ≥ clog2(V_ACTIVE+V_BLANK).

Decomposition:
- Shared package camerica_pkg:
  - pattern_t enum (PAT_RAMP, PAT_CHECKER, PAT_EXT, PAT_CONST).
  - PIXEL_W=12.
  - PAT_CONST_VALUE=12'hA5A.
- Sub-module cam_tx_clkgen: divider producing cam_clk and the update strobe.
- Timing counters, FSM and pattern mux live in cam_tx.

Test Plan:
- Reset: hold rst=0 with enable=1 → every output 0. Release → first frame starts at the first update cycle, slot (0,0).
- Default params, ramp, enable held 3 frames:
  - hsync high for 320 consecutive slots per line, on 256 lines.
  - vsync high for 256×352 slots.
  - pixel at (10,2) = 18.
  - 3 frame_done pulses; frame_count=3.
  - Receiver recovers identical frames.
- CLK_DIV=1 and CLK_DIV=3: cam_clk period is 2 and 6 clk; data changes only on falling cam_clk, stable at rising.
- External mode:
  - Always-valid incrementing source → exactly 320×256 src_ready pulses per frame; cam_pixel matches the source order.
  - Drop src_valid for one visible slot → that pixel=0, underflow=1 and stays set.
- Drop enable at line 100 → the frame completes all 264 lines, frame_done pulses, then IDLE; busy falls on the same cycle.
- frame_count preloaded near wrap (force) → 16'hFFFF increments to 0.
